// File: rtl/mux_arb_if.sv
// Flit handshake bundle between two input ports, the downstream sink and the mux_arb arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives the ports.
interface mux_arb_if #(
    parameter int TYPEW = 2
);
    logic             ivalid_0;
    logic [TYPEW-1:0] itype_0;
    logic             ivalid_1;
    logic [TYPEW-1:0] itype_1;
    logic             oready;
    logic [1:0]       sel;
    logic             iready_0;
    logic             iready_1;
    logic             busy;
    logic             err_timeout;

    modport master (
        output ivalid_0, itype_0, ivalid_1, itype_1, oready,
        input  sel, iready_0, iready_1, busy, err_timeout
    );

    modport slave (
        input  ivalid_0, itype_0, ivalid_1, itype_1, oready,
        output sel, iready_0, iready_1, busy, err_timeout
    );
endinterface

// File: rtl/mux_arb.sv
// Two-port packet-locking flit arbiter: a HEAD flit wins the lock, which is held until TAIL.
// Optional idle-lock watchdog is compiled in with MUX_ARB_TIMEOUT_EN (forced release after TIMEOUT).
module mux_arb #(
    parameter int TYPEW   = 2,
    parameter int TIMEOUT = 16
) (
    input logic    clk,
    input logic    rst,
    mux_arb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOCK0 = 2'b01,
        LOCK1 = 2'b10
    } state_t;

    localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(1);
    localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(3);

    state_t                  state, state_nxt;
    logic                    rr, rr_nxt;
    logic [1:0]              ivalid;
    logic [1:0][TYPEW-1:0]   itype;
    logic [1:0]              head;
    logic [1:0]              iready;
    logic                    locked;
    logic                    own;
    logic                    xfer;
    logic                    timeout_hit;

    assign ivalid = {bus.ivalid_1, bus.ivalid_0};
    assign itype  = {bus.itype_1, bus.itype_0};

    assign locked = (state != IDLE);
    assign own    = (state == LOCK1);
    // A forced release wins over a late flit so nothing is consumed on the way out.
    assign xfer   = locked && ivalid[own] && bus.oready && !timeout_hit;

    for (genvar p = 0; p < 2; p++) begin : g_port
        assign head[p]   = ivalid[p] && (itype[p] == T_HEAD);
        assign iready[p] = xfer && (own == 1'(p));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rr    <= 1'b0;
        end else begin
            state <= state_nxt;
            rr    <= rr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        case (state)
            IDLE: begin
                if (head[0] && head[1])
                    state_nxt = rr ? LOCK1 : LOCK0;
                else if (head[0])
                    state_nxt = LOCK0;
                else if (head[1])
                    state_nxt = LOCK1;
            end
            default: begin
                // Release always passes through IDLE, so the lock never hops ports directly.
                if ((xfer && (itype[own] == T_TAIL)) || timeout_hit) begin
                    state_nxt = IDLE;
                    rr_nxt    = ~own;
                end
            end
        endcase
    end

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] idle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idle_cnt <= '0;
        else if (!locked || xfer || timeout_hit)
            idle_cnt <= '0;
        else if (!ivalid[own])
            idle_cnt <= idle_cnt + 1'b1;
    end

    assign timeout_hit = locked && (idle_cnt == CW'(TIMEOUT));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
`endif

    assign bus.sel         = state;
    assign bus.busy        = locked;
    assign bus.iready_0    = iready[0];
    assign bus.iready_1    = iready[1];
    assign bus.err_timeout = timeout_hit;
endmodule

// File: tb/tb_mux_arb.sv
// Directed bench for mux_arb: reset, single packet, contention, backpressure, blocking,
// idle-lock timeout (behaviour follows MUX_ARB_TIMEOUT_EN) and reset mid-packet.
module tb_mux_arb;
    localparam logic [1:0] NONE = 2'b00, HEAD = 2'b01, DATA = 2'b10, TAIL = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mux_arb_if #(.TYPEW(2)) bus ();

    mux_arb #(.TYPEW(2), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int p, input logic v, input logic [1:0] t);
        if (p == 0) begin
            bus.ivalid_0 = v;
            bus.itype_0  = t;
        end else begin
            bus.ivalid_1 = v;
            bus.itype_1  = t;
        end
        #1;
    endtask

    initial begin
        int n;
        bus.ivalid_0 = 1'b0; bus.itype_0 = NONE;
        bus.ivalid_1 = 1'b0; bus.itype_1 = NONE;
        bus.oready   = 1'b1;
        #2;
        chk("rst_sel", 32'(bus.sel), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_irdy", 32'({bus.iready_1, bus.iready_0}), 0);
        chk("rst_err", 32'(bus.err_timeout), 0);
        tick();
        rst = 1'b0;

        // Non-HEAD flit in IDLE is ignored
        drv(0, 1'b1, DATA);
        tick();
        chk("idle_data_ignored", 32'(bus.sel), 0);
        drv(0, 1'b0, NONE);

        // Single packet on port 1: HEAD, 20 DATA, TAIL
        drv(1, 1'b1, HEAD);
        chk("p1_idle_irdy", 32'(bus.iready_1), 0);
        tick();
        chk("p1_grant", 32'(bus.sel), 2);
        n = 0;
        for (int i = 0; i < 22; i++) begin
            drv(1, 1'b1, (i == 0) ? HEAD : (i == 21) ? TAIL : DATA);
            if (bus.iready_1 && bus.sel == 2'b10) n++;
            tick();
        end
        drv(1, 1'b0, NONE);
        chk("p1_irdy_cycles", 32'(n), 22);
        chk("p1_release_sel", 32'(bus.sel), 0);
        chk("p1_release_busy", 32'(bus.busy), 0);

        // Contention right after reset: rr = 0 favours port 0
        rst = 1'b1; #1; rst = 1'b0;
        drv(0, 1'b1, HEAD);
        drv(1, 1'b1, HEAD);
        tick();
        chk("cont_first", 32'(bus.sel), 1);
        chk("cont_p1_blocked", 32'(bus.iready_1), 0);
        tick();                     // port 0 HEAD consumed
        drv(0, 1'b1, TAIL);
        chk("cont_p0_tail_irdy", 32'(bus.iready_0), 1);
        tick();
        drv(0, 1'b1, HEAD);         // port 0 re-requests
        chk("cont_gap", 32'(bus.sel), 0);
        tick();
        chk("cont_second", 32'(bus.sel), 2);
        tick();                     // port 1 HEAD consumed
        drv(1, 1'b1, TAIL);
        tick();
        drv(0, 1'b0, NONE);
        drv(1, 1'b0, NONE);
        chk("cont_done", 32'(bus.sel), 0);
        tick();

        // Backpressure mid-packet on port 0
        drv(0, 1'b1, HEAD);
        tick();
        tick();                     // HEAD consumed
        drv(0, 1'b1, DATA);
        bus.oready = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.iready_0 || bus.sel != 2'b01) n++;
            tick();
        end
        chk("bp_stall_viol", 32'(n), 0);
        bus.oready = 1'b1;
        #1;
        chk("bp_data_accepted", 32'(bus.iready_0), 1);
        tick();
        drv(0, 1'b1, TAIL);
        chk("bp_tail_accepted", 32'(bus.iready_0), 1);
        tick();
        drv(0, 1'b0, NONE);
        chk("bp_release", 32'(bus.sel), 0);

        // Port 1 HEAD during LOCK0 waits for the TAIL plus one IDLE cycle
        drv(0, 1'b1, HEAD);
        tick();
        tick();
        drv(0, 1'b1, DATA);
        drv(1, 1'b1, HEAD);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.iready_1) n++;
            tick();
        end
        chk("blk_p1_irdy", 32'(n), 0);
        drv(0, 1'b1, TAIL);
        chk("blk_p1_irdy_tail", 32'(bus.iready_1), 0);
        tick();
        drv(0, 1'b0, NONE);
        chk("blk_gap", 32'(bus.sel), 0);
        tick();
        chk("blk_p1_grant", 32'(bus.sel), 2);
        tick();                     // port 1 HEAD consumed
        drv(1, 1'b1, TAIL);
        tick();
        drv(1, 1'b0, NONE);

        // Idle lock on port 0
        drv(0, 1'b1, HEAD);
        tick();
        tick();
        drv(0, 1'b0, NONE);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.err_timeout) n++;
            tick();
        end
`ifdef MUX_ARB_TIMEOUT_EN
        chk("to_pulses", 32'(n), 1);
        chk("to_sel", 32'(bus.sel), 0);
        chk("to_busy", 32'(bus.busy), 0);
`else
        chk("to_pulses", 32'(n), 0);
        chk("to_sel_held", 32'(bus.sel), 1);
        chk("to_busy_held", 32'(bus.busy), 1);
        drv(0, 1'b1, TAIL);
        tick();
        drv(0, 1'b0, NONE);
        chk("to_tail_release", 32'(bus.sel), 0);
`endif
        tick();

        // Reset mid-packet in LOCK1
        drv(1, 1'b1, HEAD);
        tick();
        tick();
        drv(1, 1'b1, DATA);
        chk("rm_locked", 32'(bus.sel), 2);
        rst = 1'b1;
        #1;
        chk("rm_sel", 32'(bus.sel), 0);
        chk("rm_busy", 32'(bus.busy), 0);
        chk("rm_irdy", 32'({bus.iready_1, bus.iready_0}), 0);
        #2;
        rst = 1'b0;
        tick();
        tick();
        chk("rm_data_ignored_sel", 32'(bus.sel), 0);
        chk("rm_data_ignored_irdy", 32'(bus.iready_1), 0);
        drv(1, 1'b1, HEAD);
        tick();
        chk("rm_fresh_grant", 32'(bus.sel), 2);
        drv(1, 1'b0, NONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
